// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : push-button synchronizer and debouncer producing a clean
//                level plus press, release and long-press pulses
// Revision     : 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_pulse,
  output logic o_release,
  output logic o_long
);

  localparam int c_cnt_max = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               w_pr;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_pulse_nxt;
  logic               w_release_nxt;
  logic               r_level;
  logic               r_pulse;
  logic               r_release;

  // Synchronizer idles at the unpressed pin level so a held key is seen as a fresh press
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pr = r_sync2 ^ ACTIVE_LOW;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_WAIT);
      r_pulse   <= w_pulse_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_RELEASED: begin
        if (w_pr) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_pr) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PRESSED: begin
        if (!w_pr) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (w_pr) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_deb_last) begin
          w_state_nxt   = S_RELEASED;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      localparam logic [c_cnt_w-1:0] c_hold_max  = c_cnt_w'(HOLD_CYCLES);
      localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);

      logic               w_hold_inc;
      logic [c_cnt_w-1:0] r_hold;
      logic               r_long;

      // Only counts while settled in PRESSED; frozen across a release bounce
      assign w_hold_inc = (r_state == S_PRESSED) && w_pr;

      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else begin
          if (w_pulse_nxt) begin
            r_hold <= '0;
          end else if (w_hold_inc && (r_hold != c_hold_max)) begin
            r_hold <= r_hold + 1'b1;
          end
          r_long <= w_hold_inc && (r_hold == c_hold_last);
        end
      end

      assign o_long = r_long;
    end else begin : g_no_hold
      assign o_long = 1'b0;
    end
  endgenerate

  assign o_level   = r_level;
  assign o_pulse   = r_pulse;
  assign o_release = r_release;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low instance with long-press and an
// active-high instance without, both driven by the same physical key.
`default_nettype none

module tb_key_debounce;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b1;
  logic key_b;
  logic la, pa, ra, ga;
  logic lb, pb, rb, gb;

  assign key_b = ~key;

  key_debounce #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_key(key),
    .o_level(la), .o_pulse(pa), .o_release(ra), .o_long(ga)
  );

  key_debounce #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(0), .ACTIVE_LOW(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_key(key_b),
    .o_level(lb), .o_pulse(pb), .o_release(rb), .o_long(gb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level change is accepted once the synchronized key has
  // disagreed with the accepted level on D+1 consecutive edges; the hold count
  // advances on edges where the key has agreed with an accepted press throughout.
  int hold_lim[2] = '{10, 0};
  bit m_s1[2], m_s2[2], m_level[2];
  int m_run[2], m_hold[2];
  bit exp_p[2], exp_r[2], exp_g[2];
  bit m_pr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_level[i] = 1'b0;
        m_run[i] = 0; m_hold[i] = 0;
        exp_p[i] = 1'b0; exp_r[i] = 1'b0; exp_g[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_pr = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = ~key;
        exp_p[i] = 1'b0; exp_r[i] = 1'b0; exp_g[i] = 1'b0;
        if (m_pr != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_level[i] = m_pr;
            m_run[i] = 0;
            if (m_pr) begin
              exp_p[i] = 1'b1;
              m_hold[i] = 0;
            end else begin
              exp_r[i] = 1'b1;
            end
          end
        end else begin
          if (m_level[i] && m_run[i] == 0 && m_hold[i] < hold_lim[i]) begin
            m_hold[i]++;
            if (m_hold[i] == hold_lim[i]) exp_g[i] = 1'b1;
          end
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_level",   la, m_level[0]);
      check("a_pulse",   pa, exp_p[0]);
      check("a_release", ra, exp_r[0]);
      check("a_long",    ga, exp_g[0]);
      check("b_level",   lb, m_level[1]);
      check("b_pulse",   pb, exp_p[1]);
      check("b_release", rb, exp_r[1]);
      check("b_long",    gb, exp_g[1]);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Counts dut_a events over n cycles; first_* are 1-based cycle indices, 0 if none
  task automatic count_a(input int n, output int np, output int nr, output int ng,
                         output int nl, output int first_p, output int first_g);
    np = 0; nr = 0; ng = 0; nl = 0; first_p = 0; first_g = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (pa) begin np++; if (first_p == 0) first_p = k; end
      if (ga) begin ng++; if (first_g == 0) first_g = k; end
      if (ra) nr++;
      if (la) nl++;
    end
  endtask

  // Change key just before edge 1 and check the edge-7 event against literals
  task automatic edge_check(input string tag, input logic new_key, input bit press);
    key = new_key;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (press) begin
        check($sformatf("%s_a_pulse_e%0d", tag, k), pa, k == 7);
        check($sformatf("%s_b_pulse_e%0d", tag, k), pb, k == 7);
        check($sformatf("%s_a_level_e%0d", tag, k), la, k >= 7);
        check($sformatf("%s_b_level_e%0d", tag, k), lb, k >= 7);
        check($sformatf("%s_model_pulse_e%0d", tag, k), exp_p[0], k == 7);
      end else begin
        check($sformatf("%s_a_rel_e%0d", tag, k), ra, k == 7);
        check($sformatf("%s_b_rel_e%0d", tag, k), rb, k == 7);
        check($sformatf("%s_a_level_e%0d", tag, k), la, k < 7);
        check($sformatf("%s_b_level_e%0d", tag, k), lb, k < 7);
        check($sformatf("%s_model_rel_e%0d", tag, k), exp_r[0], k == 7);
      end
    end
  endtask

  initial begin
    int np, nr, ng, nl, fp, fg, t;

    idle(3);
    cmp_en = 1'b1;
    rst = 1'b1;

    // Idle after reset: nothing fires
    count_a(50, np, nr, ng, nl, fp, fg);
    check_int("idle_events", np + nr + ng + nl, 0);

    // Clean press and release
    edge_check("press", 1'b0, 1'b1);
    idle(20);
    edge_check("release", 1'b1, 1'b0);
    idle(10);

    // Bounce every 2 cycles never reaches the debounce threshold
    np = 0; nl = 0;
    for (int k = 0; k < 40; k++) begin
      key = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (pa) np++;
      if (la) nl++;
    end
    key = 1'b1;
    count_a(10, t, nr, ng, fp, fp, fg);
    check_int("bounce_pulses", np + t, 0);
    check_int("bounce_level_cycles", nl + fp, 0);
    key = 1'b0;
    count_a(20, np, nr, ng, nl, fp, fg);
    check_int("post_bounce_pulses", np, 1);
    key = 1'b1;
    idle(20);

    // Long press with a short release glitch mid-hold
    key = 1'b0;
    count_a(30, np, nr, ng, nl, fp, fg);
    check_int("long_pulses", np, 1);
    check_int("long_pulse_at", fp, 7);
    check_int("long_count", ng, 1);
    check_int("long_at", fg, 17);
    key = 1'b1;
    idle(3);
    key = 1'b0;
    count_a(30, np, nr, ng, nl, fp, fg);
    check_int("glitch_pulses", np, 0);
    check_int("glitch_releases", nr, 0);
    check_int("glitch_longs", ng, 0);
    key = 1'b1;
    count_a(20, np, nr, ng, nl, fp, fg);
    check_int("long_release_count", nr, 1);
    check_int("long_after_release", ng, 0);

    // Reset mid-press: outputs clear at once; held key gives a fresh press
    key = 1'b0;
    t = 0;
    while (!la && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_level_reached", la, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_a_level", la, 1'b0);
    check("async_b_level", lb, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("rst_hold_pulse_e%0d", k), pa, k == 7);
    end
    key = 1'b1;
    idle(20);

    // Random key activity with occasional resets
    for (int s = 0; s < 200; s++) begin
      key = ($urandom_range(0, 3) == 0) ? key : ~key;
      t = $urandom_range(1, 25);
      for (int k = 0; k < t; k++) @(negedge clk);
      if ($urandom_range(0, 40) == 0) begin
        #3 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    key = 1'b1;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

`default_nettype wire
